ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It is the outbound counterpart of the existing PS/2 keyboard receive path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset. Uses open-drain control of the shared ps2_clk/ps2_din lines.
- Sits beside the PS/2 receiver in the apple1 core on the clk25 domain.
- Asserts rx_inhibit so the receiver ignores line activity while a transmission is in progress.

Parameters:
- INHIBIT_CYCLES, 2500: clk25 cycles the clock line is held low before the start bit (100 us at 25 MHz).
- TIMEOUT_CYCLES, 50000: maximum clk25 cycles allowed between consecutive device clock falling edges (2 ms).

Ports:
- clk25  input  1  system clock, 25 MHz.
- rst  input  1  asynchronous reset, active high.
- tx_data  input  8  command byte to send.
- tx_valid  input  1  request; accepted only when tx_ready=1.
- tx_ready  output  1  high in IDLE.
- ps2_clk_in  input  1  raw PS/2 clock pin level (pulled up).
- ps2_din_in  input  1  raw PS/2 data pin level (pulled up).
- ps2_clk_oe  output  1  1 = drive clock line low; 0 = release.
- ps2_din_oe  output  1  1 = drive data line low; 0 = release.
- rx_inhibit  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse at the end of every attempt.
- ack_err  output  1  valid with done: device did not drive the ack bit low.
- timeout  output  1  valid with done: clock-edge timeout occurred.

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; both oe outputs go to 0 (lines released).
  - done, ack_err, timeout = 0; tx_ready = 1; rx_inhibit = 0.
  - All counters cleared.
- Input synchronisation:
  - ps2_clk_in and ps2_din_in each pass through a 2-flop synchroniser; call the outputs clk_s and din_s.
  - fall = clk_s(previous cycle) & ~clk_s.
- Handshake:
  - tx_valid & tx_ready latches tx_data and odd parity (~^tx_data), then moves to INHIBIT.
  - tx_valid is ignored when not IDLE; no queueing.
- State machine:
  - IDLE: both oe = 0.
  - INHIBIT: clk_oe = 1. Count INHIBIT_CYCLES cycles, then go to START with din_oe = 1.
  - START: din_oe = 1, clk_oe = 0. Clear edge counter (0..10) and timeout counter.
  - Edges 1-8: on fall number n, din_oe = ~data[n-1] (LSB first).
  - Edge 9: din_oe = ~parity.
  - Edge 10: din_oe = 0 (stop bit, line released).
  - Edge 11 (ACK): sample din_s; ack_err = din_s. Go to WAIT_IDLE.
  - WAIT_IDLE: wait for clk_s = 1 and din_s = 1. Then pulse done with ack_err for one cycle and return to IDLE.
- Timeout:
  - Counter runs in START through ACK and clears on every fall.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse done with timeout = 1 and ack_err = 0, go to IDLE.
  - WAIT_IDLE uses the same counter; expiry there sets timeout in the same way.
- rx_inhibit is registered and high from the cycle after acceptance until IDLE is re-entered.
- A fall observed during INHIBIT (our own drive) is ignored.
- Simultaneous tx_valid and done: the new request is accepted on the cycle after done, once IDLE/tx_ready=1.
- tx_ready deasserts in the cycle after acceptance. done, ack_err and timeout are each high for exactly one cycle per attempt.
- Sizing: timeout counter is $clog2(TIMEOUT_CYCLES+1) bits wide; inhibit counter is $clog2(INHIBIT_CYCLES+1) bits wide.

Test Plan:
- Send 0xED with a device model that clocks at a 40 us period and acks.
  - clk_oe low for exactly 2500 cycles.
  - Device samples start 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done pulses once with ack_err = 0 and timeout = 0.
- Send 0x07: parity bit sampled = 0. Send 0x00: parity bit sampled = 1.
- Device model leaves data high at edge 11: done with ack_err = 1. tx_ready returns to 1 after the lines go idle.
- Device model stops clocking after edge 4: exactly 50000 cycles after the 4th fall, done with timeout = 1, both oe = 0, state IDLE.
- Assert rst during DATA after edge 5: oe outputs go to 0 in the same cycle without a clock edge. After release, tx_ready = 1 and rx_inhibit = 0. A new 0xFF transfer completes cleanly.
- Pulse tx_valid with 0x55 while busy sending 0xED: the 0x55 is ignored and the device receives only 0xED.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one command byte
// on device-generated clocks, checks the device ack and reports on done.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_din_in,
    output logic       ps2_clk_oe,
    output logic       ps2_din_oe,
    output logic       rx_inhibit,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned EDGE_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_DATA,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_clk_s1, r_clk_s2, r_clk_prev;
    logic                r_din_s1, r_din_s2;
    logic [7:0]          r_data, w_data_nxt;
    logic                r_parity, w_parity_nxt;
    logic [INH_W-1:0]    r_inh_cnt, w_inh_cnt_nxt;
    logic [TO_W-1:0]     r_to_cnt, w_to_cnt_nxt;
    logic [EDGE_W-1:0]   r_edge_cnt, w_edge_cnt_nxt;
    logic                r_ack_bit, w_ack_bit_nxt;
    logic                r_clk_oe, w_clk_oe_nxt;
    logic                r_din_oe, w_din_oe_nxt;
    logic                r_done, w_done_nxt;
    logic                r_ack_err, w_ack_err_nxt;
    logic                r_timeout, w_timeout_nxt;
    logic                r_tx_ready, r_rx_inhibit;
    logic                w_fall, w_to_hit, w_inh_hit;

    // Pins idle high (pulled up), so synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_din_s1   <= 1'b1;
            r_din_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_din_s1   <= ps2_din_in;
            r_din_s2   <= r_din_s1;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_to_hit  = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_inh_hit = (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1));

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_data       <= 8'h00;
            r_parity     <= 1'b0;
            r_inh_cnt    <= '0;
            r_to_cnt     <= '0;
            r_edge_cnt   <= '0;
            r_ack_bit    <= 1'b0;
            r_clk_oe     <= 1'b0;
            r_din_oe     <= 1'b0;
            r_done       <= 1'b0;
            r_ack_err    <= 1'b0;
            r_timeout    <= 1'b0;
            r_tx_ready   <= 1'b1;
            r_rx_inhibit <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_data       <= w_data_nxt;
            r_parity     <= w_parity_nxt;
            r_inh_cnt    <= w_inh_cnt_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_edge_cnt   <= w_edge_cnt_nxt;
            r_ack_bit    <= w_ack_bit_nxt;
            r_clk_oe     <= w_clk_oe_nxt;
            r_din_oe     <= w_din_oe_nxt;
            r_done       <= w_done_nxt;
            r_ack_err    <= w_ack_err_nxt;
            r_timeout    <= w_timeout_nxt;
            r_tx_ready   <= (w_state_nxt == S_IDLE);
            r_rx_inhibit <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_data_nxt     = r_data;
        w_parity_nxt   = r_parity;
        w_inh_cnt_nxt  = r_inh_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_edge_cnt_nxt = r_edge_cnt;
        w_ack_bit_nxt  = r_ack_bit;
        w_clk_oe_nxt   = r_clk_oe;
        w_din_oe_nxt   = r_din_oe;
        w_done_nxt     = 1'b0;
        w_ack_err_nxt  = 1'b0;
        w_timeout_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_clk_oe_nxt = 1'b0;
                w_din_oe_nxt = 1'b0;
                if (tx_valid && r_tx_ready) begin
                    w_data_nxt    = tx_data;
                    w_parity_nxt  = ~^tx_data;
                    w_inh_cnt_nxt = '0;
                    w_clk_oe_nxt  = 1'b1;
                    w_state_nxt   = S_INHIBIT;
                end
            end
            // Falls seen here come from our own clock drive and are ignored.
            S_INHIBIT: begin
                if (w_inh_hit) begin
                    w_clk_oe_nxt   = 1'b0;
                    w_din_oe_nxt   = 1'b1;
                    w_edge_cnt_nxt = '0;
                    w_to_cnt_nxt   = '0;
                    w_state_nxt    = S_START;
                end else begin
                    w_inh_cnt_nxt = r_inh_cnt + INH_W'(1);
                end
            end
            S_START, S_DATA, S_ACK: begin
                if (w_fall) begin
                    w_to_cnt_nxt = '0;
                    if (r_state == S_ACK) begin
                        w_ack_bit_nxt = r_din_s2;
                        w_state_nxt   = S_WAIT_IDLE;
                    end else begin
                        w_edge_cnt_nxt = r_edge_cnt + EDGE_W'(1);
                        w_state_nxt    = S_DATA;
                        if (r_edge_cnt < EDGE_W'(8)) begin
                            w_din_oe_nxt = ~r_data[r_edge_cnt[2:0]];
                        end else if (r_edge_cnt == EDGE_W'(8)) begin
                            w_din_oe_nxt = ~r_parity;
                        end else begin
                            w_din_oe_nxt = 1'b0;
                            w_state_nxt  = S_ACK;
                        end
                    end
                end else if (w_to_hit) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_din_oe_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                w_din_oe_nxt = 1'b0;
                if (r_clk_s2 && r_din_s2) begin
                    w_done_nxt    = 1'b1;
                    w_ack_err_nxt = r_ack_bit;
                    w_state_nxt   = S_IDLE;
                end else if (w_to_hit) begin
                    w_clk_oe_nxt  = 1'b0;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + TO_W'(1);
                end
            end
            default: begin
                w_clk_oe_nxt = 1'b0;
                w_din_oe_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    assign tx_ready   = r_tx_ready;
    assign rx_inhibit = r_rx_inhibit;
    assign ps2_clk_oe = r_clk_oe;
    assign ps2_din_oe = r_din_oe;
    assign done       = r_done;
    assign ack_err    = r_ack_err;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and
// the received bits are compared with frames built from the byte sent.
module tb_ps2_host_tx;

    localparam int unsigned INH   = 100;
    localparam int unsigned TO    = 400;
    localparam int unsigned HP    = 20;
    localparam int unsigned LIMIT = 5000;

    logic       clk25 = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in, ps2_din_in;
    logic       ps2_clk_oe, ps2_din_oe;
    logic       rx_inhibit, done, ack_err, timeout;
    logic       dev_clk_low, dev_din_low;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run      = 0;
    int last_run = 0;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk25(clk25), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_din_in(ps2_din_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_din_oe(ps2_din_oe), .rx_inhibit(rx_inhibit),
        .done(done), .ack_err(ack_err), .timeout(timeout)
    );

    // Open-drain bus: either side may pull a line low.
    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_din_in = ~(ps2_din_oe | dev_din_low);

    always #5 clk25 = ~clk25;

    always @(posedge clk25) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe) run <= run + 1;
        else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Device: waits for start condition, reads start bit, then clocks n_edges falls.
    task automatic dev_run(input int n_edges, input bit do_ack, output logic [10:0] samp,
                           output bit ok, output int fall4_cyc);
        samp = '0;
        ok = 0;
        fall4_cyc = 0;
        for (int i = 0; i < LIMIT; i++) begin
            if (ps2_clk_in && !ps2_din_in) begin
                ok = 1;
                break;
            end
            tick(1);
        end
        if (ok) begin
            tick(HP);
            samp[0] = ps2_din_in;
            for (int e = 1; e <= n_edges; e++) begin
                dev_clk_low = 1'b1;
                if (e == 4) fall4_cyc = cyc;
                tick(HP);
                dev_clk_low = 1'b0;
                if (e <= 10) samp[e] = ps2_din_in;
                if (e == 10 && do_ack) dev_din_low = 1'b1;
                if (e == 11) dev_din_low = 1'b0;
                tick(HP);
            end
        end
    endtask

    task automatic watch_done(output bit got, output bit a, output bit t, output int dc,
                              output bit oe_any, output bit rdy, output bit clk_line,
                              output bit dn2);
        got = 0; a = 0; t = 0; dc = 0; oe_any = 0; rdy = 0; clk_line = 0; dn2 = 0;
        for (int i = 0; i < 4 * LIMIT; i++) begin
            tick(1);
            if (done) begin
                got = 1; a = ack_err; t = timeout; dc = cyc;
                oe_any = ps2_clk_oe | ps2_din_oe; rdy = tx_ready; clk_line = ps2_clk_in;
                break;
            end
        end
        if (got) begin
            tick(1);
            dn2 = done | ack_err | timeout;
        end
    endtask

    task automatic request(input logic [7:0] d);
        bit seen = 0;
        for (int i = 0; i < LIMIT; i++) begin
            if (tx_ready) begin
                seen = 1;
                break;
            end
            tick(1);
        end
        check_eq("ready_wait", 32'(seen), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check_eq("busy_after_accept", {29'd0, tx_ready, rx_inhibit, ps2_clk_oe}, 32'b011);
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input int n_edges,
                        input bit do_ack, input bit poke);
        logic [10:0] samp;
        bit ok, got, a, t, oe_any, rdy, clk_line, dn2;
        int f4, dc;
        request(d);
        fork
            dev_run(n_edges, do_ack, samp, ok, f4);
            watch_done(got, a, t, dc, oe_any, rdy, clk_line, dn2);
            if (poke) begin
                tick(6 * HP);
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                tick(1);
                tx_valid = 1'b0;
            end
        join
        check_eq({tag, "_start_seen"}, 32'(ok), 32'd1);
        check_eq({tag, "_done"}, 32'(got), 32'd1);
        check_eq({tag, "_done_1cyc"}, 32'(dn2), 32'd0);
        check_eq({tag, "_idle_lines"}, {30'd0, oe_any, rdy}, 32'b01);
        if (n_edges == 11) begin
            check_eq({tag, "_frame"}, 32'(samp), 32'(frame(d)));
            check_eq({tag, "_inhibit_len"}, 32'(last_run), 32'(INH));
            check_eq({tag, "_flags"}, {30'd0, a, t}, {30'd0, ~do_ack, 1'b0});
            check_eq({tag, "_clk_released"}, 32'(clk_line), 32'd1);
        end else begin
            check_eq({tag, "_flags"}, {30'd0, a, t}, 32'b01);
            // Three cycles of synchroniser/edge-detect latency before the counter clears.
            check_eq({tag, "_to_delay"}, 32'(dc - f4), 32'(TO + 3));
        end
    endtask

    initial begin
        logic [10:0] samp;
        bit ok;
        int f4;
        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_din_low = 1'b0;
        tick(3);
        check_eq("reset_outs", {26'd0, tx_ready, rx_inhibit, ps2_clk_oe, ps2_din_oe, done, ack_err | timeout},
                 32'b100000);
        rst = 1'b0;
        tick(2);

        xfer("ed", 8'hED, 11, 1, 0);
        xfer("x07", 8'h07, 11, 1, 0);
        xfer("x00", 8'h00, 11, 1, 0);
        for (int i = 0; i < 6; i++) xfer("rand", 8'($urandom_range(0, 255)), 11, 1, 0);
        xfer("nack", 8'($urandom_range(0, 255)), 11, 0, 0);
        xfer("tmo", 8'($urandom_range(0, 255)), 4, 1, 0);
        xfer("busy", 8'hED, 11, 1, 1);
        tick(50);
        check_eq("no_queue", {30'd0, rx_inhibit, tx_ready}, 32'b01);

        // Asynchronous reset in the middle of the data bits.
        request(8'hA5);
        dev_run(5, 1, samp, ok, f4);
        check_eq("rst_start_seen", 32'(ok), 32'd1);
        check_eq("rst_busy", 32'(rx_inhibit), 32'd1);
        @(negedge clk25);
        #2 rst = 1'b1;
        #1 check_eq("rst_async_oe", {30'd0, ps2_clk_oe, ps2_din_oe}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check_eq("rst_recover", {30'd0, tx_ready, rx_inhibit}, 32'b10);
        xfer("ff", 8'hFF, 11, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
